// File: rtl/test_dff_pkg.sv
// Shared constants for the test_dff register bank.
package test_dff_pkg;
  localparam int unsigned MIN_COUNT = 1;
  localparam int unsigned MAX_COUNT = 1024;
endpackage

// File: rtl/dff_bit.sv
// Single-bit D flop with synchronous active-low reset to a fixed value.
module dff_bit #(
  parameter logic g_reset_value = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Only a definite 0 resets; X/Z on rst_n falls through to capture.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= g_reset_value;
    else        q <= d;
  end

endmodule

// File: rtl/test_dff.sv
// Reference register bank: g_count independent flops, q is d delayed one clock.
module test_dff
  import test_dff_pkg::*;
#(
  parameter int unsigned           g_count       = 1,
  parameter logic [g_count-1:0]    g_reset_value = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [g_count-1:0] d,
  output logic [g_count-1:0] q
);

  if (g_count < MIN_COUNT || g_count > MAX_COUNT) begin : g_bad_count
    $error("test_dff: g_count out of range");
  end

  for (genvar i = 0; i < g_count; i++) begin : g_bit
    dff_bit #(
      .g_reset_value (g_reset_value[i])
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_test_dff.sv
// Self-checking bench for test_dff: directed corners plus random equivalence on three configurations.
module tb_test_dff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d16, q16;
  logic [0:0]  d1, q1;
  logic [7:0]  d8, q8;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #2 clk = ~clk;

  test_dff #(.g_count(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .d(d16), .q(q16));
  test_dff #(.g_count(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .d(d1),  .q(q1));
  test_dff #(.g_count(8), .g_reset_value(8'h5A)) u_dut8 (.clk(clk), .rst_n(rst_n), .d(d8), .q(q8));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each bit: ~37% one, ~13% X, otherwise zero.
  function automatic logic [15:0] rand_bits();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 37)      v[i] = 1'b1;
      else if (r < 50) v[i] = 1'bx;
      else             v[i] = 1'b0;
    end
    return v;
  endfunction

  task automatic chk_all(input string tag, input logic [15:0] e16, input logic [0:0] e1,
                         input logic [7:0] e8);
    chk({tag, "_q16"}, q16, e16);
    chk({tag, "_q1"},  16'(q1), 16'(e1));
    chk({tag, "_q8"},  16'(q8), 16'(e8));
  endtask

  initial begin
    logic [15:0] xpat;
    logic [15:0] e16;
    logic [0:0]  e1;
    logic [7:0]  e8;
    logic [15:0] r;

    xpat  = 16'b0000_xxxx_1111_0000;
    rst_n = 1'b0;
    d16   = 16'hFFFF;
    d1    = 1'b1;
    d8    = 8'hFF;

    // Reset held for three edges with all-ones data.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 16'h0000, 1'b0, 8'h5A);
    end

    // Capture with one-cycle latency.
    rst_n = 1'b1;
    d16 = 16'hA5C3; d1 = 1'b1; d8 = 8'hC3;
    tick();
    chk_all("cap1", 16'hA5C3, 1'b1, 8'hC3);
    d16 = 16'h3C5A; d1 = 1'b0; d8 = 8'h3C;
    tick();
    chk_all("cap2", 16'h3C5A, 1'b0, 8'h3C);

    // X captured verbatim, then cleared.
    d16 = xpat;
    tick();
    chk("xprop", q16, xpat);
    d16 = 16'h0F0F;
    tick();
    chk("xclear", q16, 16'h0F0F);

    // Mid-stream reset discards data sampled at the reset edge.
    d16 = 16'hBEEF; d1 = 1'b1; d8 = 8'hEF;
    tick();
    chk_all("pre_rst", 16'hBEEF, 1'b1, 8'hEF);
    rst_n = 1'b0; d16 = 16'h1234; d1 = 1'b1; d8 = 8'h34;
    tick();
    chk_all("mid_rst", 16'h0000, 1'b0, 8'h5A);
    rst_n = 1'b1;
    tick();
    chk_all("post_rst", 16'h1234, 1'b1, 8'h34);

    // Random phase: step one half-period at a time; a rising edge lies inside every
    // second step, and the expected value is whatever was held on the inputs then.
    e16 = q16 === 16'h1234 ? 16'h1234 : 16'h1234;
    e1  = 1'b1;
    e8  = 8'h34;
    for (int k = 1; k <= 20000; k++) begin
      #2;
      if (k % 2 == 0) begin
        if (rst_n === 1'b0) begin
          e16 = 16'h0000; e1 = 1'b0; e8 = 8'h5A;
        end else begin
          e16 = d16; e1 = d1; e8 = d8;
        end
      end
      if (k % 3 == 0) begin
        chk_all("rand", e16, e1, e8);
        d16   = rand_bits();
        r     = rand_bits();
        d1    = r[0:0];
        r     = rand_bits();
        d8    = r[7:0];
        rst_n = ($urandom_range(0, 99) < 6) ? 1'b0 : 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
